stage5_msg_sched: RTL
=====================

# stage5_msg_sched

Stage-5 message scheduler. It accepts up to three parsed messages on independent valid/ready lanes and holds them in registers. It groups them into one extraction slot, bounded by a gather timeout, then drives `message_en`, `message_1..3` and per-lane `message_mux_control_m1..m3` into the stage-5 field extractors (TI4 and sibling field modules). The extractor inputs stay stable until downstream accepts the group.

## Interface
Parameters:
- `MSG_W`, default `MAX_MESSAGE_BITS`: message width.
- `TYPE_W`, default 4: width of the lane message-type code.
- `CTRL_W`, default `message_mux_control_width`: width of the mux control.
- `GATHER_CYC`, default 4: cycles to wait for further lanes after the first capture. A value of 0 means issue immediately.
- `SEQ_W`, default 8: width of the group sequence counter.

Ports:
- Clocking and reset: one clock, and reset is asynchronous and active-low. Signals are `clk` and `rst_n`.
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `lane_valid_1..3`, in, 1: lane n offers a message.
- `lane_ready_1..3`, out, 1: lane n can be captured this cycle.
- `lane_msg_1..3`, in, MSG_W: message payload.
- `lane_type_1..3`, in, TYPE_W: message type code.
- `out_ready`, in, 1: downstream consumes the issued group.
- `message_en`, out, 1: group valid and extractors enabled.
- `message_1..3`, out, MSG_W: held messages.
- `message_mux_control_m1..m3`, out, CTRL_W: per-lane field-layout select.
- `grp_seq`, out, SEQ_W: sequence number of the group being issued.

## Operation
FSM states: IDLE, GATHER, ISSUE.
- **Capture rule:** lane n is captured at a clock edge when `lane_valid_n & lane_ready_n`. Capture loads the payload, the decoded control and the `held_n` flag.
- **lane_ready_n:** equals `!held_n` in IDLE and GATHER, and is 0 in ISSUE.
- **IDLE:**
  - No capture: stay in IDLE.
  - At least one capture: go to GATHER and load the timer with GATHER_CYC.
  - Go straight to ISSUE instead when all three lanes are captured or GATHER_CYC = 0.
- **GATHER:**
  - The timer decrements every cycle.
  - Go to ISSUE when all three lanes are held (counting captures on this edge) or when the timer reaches 0.
  - A lane captured on the exiting edge joins the group.
- **ISSUE:**
  - `message_en` = 1.
  - On `out_ready` = 1: clear all `held_n`, increment `grp_seq` (wrapping modulo 2^SEQ_W), and go to IDLE.
  - On `out_ready` = 0: hold all outputs unchanged.
- **Decode:**
  - `lane_type` values 0..N-1 map to the package mux codes (`message_mux_a`, `message_mux_b`, ...).
  - Any unmapped code maps to `MUX_NONE`, so the extractor outputs `defaut_infor`.
- **Lanes not held in a group:** control is `MUX_NONE` and `message_n` is all-zero.
- **Output registers:** all outputs come straight from flops; there is no combinational path from inputs to outputs.
- **Reset values:**
  - State = IDLE.
  - `message_en` = 0.
  - `message_1..3` = 0.
  - Controls = `MUX_NONE`.
  - `grp_seq` = 0.
  - `lane_ready_1..3` = 1 after reset release.
- **Reset mid-group:** held messages are discarded.

## Timing
- **Latency, all lanes together:** all three lanes valid at edge k gives `message_en` high in the cycle after edge k (1 cycle).
- **Latency, single lane:** a single capture at edge k with no further lanes gives ISSUE entry at edge k+GATHER_CYC and `message_en` high from the following cycle.
- **Late lane:** a lane that becomes valid during ISSUE waits; it is captured in the first IDLE cycle after the group is accepted.
- **Back-to-back groups:** acceptance at edge j lets new captures occur at edge j+1 at the earliest, so there is a minimum 1-cycle bubble between groups.
- **Stability:** `message_n` and the controls are stable for the whole ISSUE period (hold-until-ready).

## Structure
- **Shared package `stage5_pkg`:**
  - `MUX_NONE` and the `message_mux_*` codes.
  - The type-to-mux mapping function.
  - The FSM state enum.
  - `defaut_infor`.
- **Sub-module `stage5_lane_hold`:** instantiated three times. It contains the payload register, the control register, `held_n`, the `lane_ready` logic and the decode.
- **Top level:** FSM, gather timer and `grp_seq`.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n` = 0 mid-ISSUE.
  - Required response: `message_en` = 0, all controls = `MUX_NONE`, `grp_seq` = 0, and `lane_ready_1..3` = 1 after release.
- **All lanes together:**
  - Stimulus: all three lanes valid together with types 0, 1, 0 and `out_ready` = 1.
  - Required response: `message_en` for exactly 1 cycle, 1 cycle after capture; controls a, b, a; `grp_seq` goes 0 → 1.
- **Single lane with timeout:**
  - Stimulus: only lane 2 valid, GATHER_CYC = 4.
  - Required response: ISSUE 4 cycles after capture; controls m1 = m3 = `MUX_NONE`; `message_1` and `message_3` = 0.
- **Late joiner and hold:**
  - Stimulus: lane 1 at cycle 0, lane 3 at cycle 2; `out_ready` held low for 5 cycles.
  - Required response: one group with both lanes; outputs constant for 5 cycles; `lane_ready` = 0 throughout; lane 2 valid during ISSUE is captured only after acceptance.
- **Unmapped type and wrap:**
  - Stimulus: an unmapped type code on one lane, then 256 groups issued.
  - Required response: the unmapped lane gets control `MUX_NONE`; `grp_seq` wraps 255 → 0.

Source files
------------

// File: rtl/stage5_pkg.sv
// stage5_pkg: shared mux codes, type decode, FSM states and defaults for the stage-5 scheduler.
package stage5_pkg;
    localparam int MAX_MESSAGE_BITS = 32;
    localparam int message_mux_control_width = 3;
    localparam int NUM_MUX = 4;
    localparam logic [message_mux_control_width-1:0] MUX_NONE = 3'd0;
    localparam logic [message_mux_control_width-1:0] message_mux_a = 3'd1;
    localparam logic [message_mux_control_width-1:0] message_mux_b = 3'd2;
    localparam logic [message_mux_control_width-1:0] message_mux_c = 3'd3;
    localparam logic [message_mux_control_width-1:0] message_mux_d = 3'd4;
    localparam logic [MAX_MESSAGE_BITS-1:0] defaut_infor = 32'h0000_defa;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GATHER = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    // Type codes 0..NUM_MUX-1 select layouts a, b, ...; anything else falls back to the default field
    function automatic logic [message_mux_control_width-1:0] type_to_mux(input logic [31:0] t);
        return (t < NUM_MUX) ? message_mux_control_width'(t + 32'd1) : MUX_NONE;
    endfunction
endpackage

// File: rtl/stage5_lane_hold.sv
// stage5_lane_hold: one lane's capture register, decoded mux control and held flag.
module stage5_lane_hold
    import stage5_pkg::*;
#(
    parameter int MSG_W = MAX_MESSAGE_BITS,
    parameter int TYPE_W = 4,
    parameter int CTRL_W = message_mux_control_width
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [MSG_W-1:0]  msg,
    input  logic [TYPE_W-1:0] type_code,
    input  logic              open,
    input  logic              clear,
    output logic              ready,
    output logic              held,
    output logic [MSG_W-1:0]  message,
    output logic [CTRL_W-1:0] ctrl
);
    assign ready = open & ~held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= 1'b0;
            message <= '0;
            ctrl <= CTRL_W'(MUX_NONE);
        end else if (clear) begin
            held <= 1'b0;
            message <= '0;
            ctrl <= CTRL_W'(MUX_NONE);
        end else if (valid && ready) begin
            held <= 1'b1;
            message <= msg;
            ctrl <= CTRL_W'(type_to_mux(32'(type_code)));
        end
    end
endmodule

// File: rtl/stage5_msg_sched.sv
// stage5_msg_sched: gathers up to three lanes into one extraction group and holds it until accepted.
module stage5_msg_sched
    import stage5_pkg::*;
#(
    parameter int MSG_W = MAX_MESSAGE_BITS,
    parameter int TYPE_W = 4,
    parameter int CTRL_W = message_mux_control_width,
    parameter int GATHER_CYC = 4,
    parameter int SEQ_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lane_valid_1,
    input  logic              lane_valid_2,
    input  logic              lane_valid_3,
    output logic              lane_ready_1,
    output logic              lane_ready_2,
    output logic              lane_ready_3,
    input  logic [MSG_W-1:0]  lane_msg_1,
    input  logic [MSG_W-1:0]  lane_msg_2,
    input  logic [MSG_W-1:0]  lane_msg_3,
    input  logic [TYPE_W-1:0] lane_type_1,
    input  logic [TYPE_W-1:0] lane_type_2,
    input  logic [TYPE_W-1:0] lane_type_3,
    input  logic              out_ready,
    output logic              message_en,
    output logic [MSG_W-1:0]  message_1,
    output logic [MSG_W-1:0]  message_2,
    output logic [MSG_W-1:0]  message_3,
    output logic [CTRL_W-1:0] message_mux_control_m1,
    output logic [CTRL_W-1:0] message_mux_control_m2,
    output logic [CTRL_W-1:0] message_mux_control_m3,
    output logic [SEQ_W-1:0]  grp_seq
);
    localparam int TW = (GATHER_CYC < 1) ? 1 : $clog2(GATHER_CYC + 1);
    logic [1:0] state, state_nx;
    logic [TW-1:0] timer;
    logic [2:0] valid_v, ready_v, held_v, cap_v;
    logic [MSG_W-1:0] msg_in [3];
    logic [MSG_W-1:0] msg_out [3];
    logic [TYPE_W-1:0] type_in [3];
    logic [CTRL_W-1:0] ctrl_out [3];
    logic open, clear, all_next;

    assign valid_v = {lane_valid_3, lane_valid_2, lane_valid_1};
    assign msg_in = '{lane_msg_1, lane_msg_2, lane_msg_3};
    assign type_in = '{lane_type_1, lane_type_2, lane_type_3};
    assign open = (state != ST_ISSUE);
    assign clear = (state == ST_ISSUE) & out_ready;
    assign cap_v = valid_v & ready_v;
    assign all_next = &(held_v | cap_v);

    for (genvar i = 0; i < 3; i++) begin : g_lane
        stage5_lane_hold #(.MSG_W(MSG_W), .TYPE_W(TYPE_W), .CTRL_W(CTRL_W)) u_lane (
            .clk(clk),
            .rst_n(rst_n),
            .valid(valid_v[i]),
            .msg(msg_in[i]),
            .type_code(type_in[i]),
            .open(open),
            .clear(clear),
            .ready(ready_v[i]),
            .held(held_v[i]),
            .message(msg_out[i]),
            .ctrl(ctrl_out[i])
        );
    end

    assign {lane_ready_3, lane_ready_2, lane_ready_1} = ready_v;
    assign message_1 = msg_out[0];
    assign message_2 = msg_out[1];
    assign message_3 = msg_out[2];
    assign message_mux_control_m1 = ctrl_out[0];
    assign message_mux_control_m2 = ctrl_out[1];
    assign message_mux_control_m3 = ctrl_out[2];

    // A lane captured on the edge that leaves GATHER still joins, since all lanes load together
    always_comb begin
        state_nx = (state == ST_IDLE) ? ((|cap_v) ? ((all_next || GATHER_CYC == 0) ? ST_ISSUE : ST_GATHER) : ST_IDLE)
                 : (state == ST_GATHER) ? ((all_next || timer <= TW'(1)) ? ST_ISSUE : ST_GATHER)
                 : (state == ST_ISSUE) ? (out_ready ? ST_IDLE : ST_ISSUE)
                 : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            message_en <= 1'b0;
            timer <= '0;
            grp_seq <= '0;
        end else begin
            state <= state_nx;
            message_en <= (state_nx == ST_ISSUE);
            timer <= (state == ST_IDLE) ? TW'(GATHER_CYC) : timer - TW'(timer != '0);
            grp_seq <= grp_seq + SEQ_W'(clear);
        end
    end
endmodule
